// File: rtl/decode_ctrl_pkg.sv
// rtl/decode_ctrl_pkg.sv - shared types, opcodes and serialisation rule for the decode stage
package decode_ctrl_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        FU_NONE, FU_ALU, FU_LSU, FU_CSR, FU_SYS
    } fu_e;

    typedef enum logic [4:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LUI, OP_AUIPC,
        OP_LW, OP_SW, OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI,
        OP_CSRRCI, OP_ECALL, OP_EBREAK, OP_SRET, OP_MRET, OP_WFI,
        OP_SFENCE_VMA, OP_FENCE, OP_FENCE_I
    } op_e;

    typedef struct packed {
        logic            valid;
        fu_e             fu;
        op_e             op;
        logic            use_imm;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
    } si_t;

    typedef enum logic [1:0] {
        RUN, DRAIN, ISSUE, WAIT
    } decode_state_e;

    // Instructions that must see an idle backend and block younger ones until committed.
    function automatic bit is_serializing(fu_e fu, op_e op, logic valid);
        return !valid || (fu == FU_CSR) ||
               (op inside {OP_SRET, OP_MRET, OP_WFI, OP_SFENCE_VMA, OP_FENCE,
                           OP_FENCE_I, OP_ECALL, OP_EBREAK, OP_CSRRW, OP_CSRRS,
                           OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI});
    endfunction

endpackage

// File: rtl/decode_ctrl_decoder.sv
// rtl/decode_ctrl_decoder.sv - static RV32I-subset decoder (ALU, LW/SW, fences, system, CSR)
module decode_ctrl_decoder
    import decode_ctrl_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [31:0]     instr,
    output si_t             si
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;
    logic            ok;
    fu_e             fu;
    op_e             op;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic            wr_rd;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u  = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};

    always_comb begin
        ok      = 1'b1;
        fu      = FU_ALU;
        op      = OP_NOP;
        imm     = '0;
        use_imm = 1'b0;
        wr_rd   = 1'b1;
        case (opcode)
            OPC_LUI: begin
                op      = OP_LUI;
                imm     = imm_u;
                use_imm = 1'b1;
            end
            OPC_AUIPC: begin
                op      = OP_AUIPC;
                imm     = imm_u;
                use_imm = 1'b1;
            end
            OPC_OP_IMM: begin
                imm     = imm_i;
                use_imm = 1'b1;
                case (funct3)
                    3'b000:  op = OP_ADD;
                    3'b100:  op = OP_XOR;
                    3'b110:  op = OP_OR;
                    3'b111:  op = OP_AND;
                    default: ok = 1'b0;
                endcase
            end
            OPC_OP: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  op = OP_ADD;
                        3'b100:  op = OP_XOR;
                        3'b110:  op = OP_OR;
                        3'b111:  op = OP_AND;
                        default: ok = 1'b0;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    op = OP_SUB;
                end else begin
                    ok = 1'b0;
                end
            end
            OPC_LOAD: begin
                fu      = FU_LSU;
                op      = OP_LW;
                imm     = imm_i;
                use_imm = 1'b1;
                ok      = (funct3 == 3'b010);
            end
            OPC_STORE: begin
                fu      = FU_LSU;
                op      = OP_SW;
                imm     = imm_s;
                use_imm = 1'b1;
                wr_rd   = 1'b0;
                ok      = (funct3 == 3'b010);
            end
            OPC_MISC_MEM: begin
                fu    = FU_SYS;
                wr_rd = 1'b0;
                case (funct3)
                    3'b000:  op = OP_FENCE;
                    3'b001:  op = OP_FENCE_I;
                    default: ok = 1'b0;
                endcase
            end
            OPC_SYSTEM: begin
                if (funct3 == 3'b000) begin
                    fu    = FU_SYS;
                    wr_rd = 1'b0;
                    case (instr)
                        32'h0000_0073: op = OP_ECALL;
                        32'h0010_0073: op = OP_EBREAK;
                        32'h1020_0073: op = OP_SRET;
                        32'h3020_0073: op = OP_MRET;
                        32'h1050_0073: op = OP_WFI;
                        default: begin
                            if (funct7 == 7'b0001001 && instr[11:7] == 5'd0) begin
                                op = OP_SFENCE_VMA;
                            end else begin
                                ok = 1'b0;
                            end
                        end
                    endcase
                end else begin
                    // CSR address travels in imm, zero-extended.
                    fu  = FU_CSR;
                    imm = {{(XLEN-12){1'b0}}, instr[31:20]};
                    case (funct3)
                        3'b001:  op = OP_CSRRW;
                        3'b010:  op = OP_CSRRS;
                        3'b011:  op = OP_CSRRC;
                        3'b101:  op = OP_CSRRWI;
                        3'b110:  op = OP_CSRRSI;
                        3'b111:  op = OP_CSRRCI;
                        default: ok = 1'b0;
                    endcase
                end
            end
            default: ok = 1'b0;
        endcase

        si    = '0;
        si.pc = pc;
        if (ok) begin
            si.valid   = 1'b1;
            si.fu      = fu;
            si.op      = op;
            si.use_imm = use_imm;
            si.imm     = imm;
            si.rd      = wr_rd ? instr[11:7] : 5'd0;
            si.rs1     = instr[19:15];
            si.rs2     = instr[24:20];
        end
    end

endmodule

// File: rtl/si_fifo2.sv
// rtl/si_fifo2.sv - 2-entry valid/ready FIFO of decoded instructions with flush
module si_fifo2
    import decode_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       flush,
    input  logic       s_tvalid,
    output logic       s_tready,
    input  si_t        s_tdata,
    output logic       m_tvalid,
    input  logic       m_tready,
    output si_t        m_tdata,
    output logic [1:0] occupancy
);

    si_t [1:0]  mem;
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;

    assign s_tready  = (count != 2'd2) && !flush;
    assign m_tvalid  = (count != 2'd0) && !flush;
    assign m_tdata   = mem[rd_ptr];
    assign occupancy = count;
    assign push      = s_tvalid && s_tready;
    assign pop       = m_tvalid && m_tready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= s_tdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/decode_ctrl.sv
// rtl/decode_ctrl.sv - decode stage: decoder, 2-entry output buffer, serialisation FSM, stall counter
module decode_ctrl
    import decode_ctrl_pkg::*;
#(
    parameter bit SERIALIZE_ALL = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            fetch_valid_i,
    output logic            fetch_ready_o,
    input  logic [XLEN-1:0] fetch_pc_i,
    input  logic [31:0]     fetch_instr_i,
    output logic            si_valid_o,
    input  logic            si_ready_i,
    output si_t             si_o,
    input  logic            backend_empty_i,
    input  logic            ser_done_i,
    output logic [31:0]     stall_cycles_o
);

    decode_state_e state;
    decode_state_e state_next;
    si_t           dec_si;
    logic          ser;
    logic          fsm_ready;
    logic          fifo_ready;
    logic          si_fire;
    logic [1:0]    occupancy;
    logic [31:0]   stall_cnt;

    decode_ctrl_decoder u_decoder (
        .pc    (fetch_pc_i),
        .instr (fetch_instr_i),
        .si    (dec_si)
    );

    assign ser = SERIALIZE_ALL || is_serializing(dec_si.fu, dec_si.op, dec_si.valid);

    si_fifo2 u_fifo (
        .clk       (clk_i),
        .resetn    (rst_ni),
        .flush     (flush_i),
        .s_tvalid  (fetch_valid_i && fetch_ready_o),
        .s_tready  (fifo_ready),
        .s_tdata   (dec_si),
        .m_tvalid  (si_valid_o),
        .m_tready  (si_ready_i),
        .m_tdata   (si_o),
        .occupancy (occupancy)
    );

    // fifo_ready only reflects occupancy and flush, so si_ready_i never reaches fetch_ready_o.
    assign fetch_ready_o = fsm_ready && fifo_ready;
    assign si_fire       = si_valid_o && si_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        fsm_ready  = 1'b0;
        if (flush_i) begin
            state_next = RUN;
        end else begin
            case (state)
                RUN: begin
                    fsm_ready = (occupancy != 2'd2) && !ser;
                    if (fetch_valid_i && ser) state_next = DRAIN;
                end
                DRAIN: begin
                    fsm_ready = (occupancy == 2'd0) && backend_empty_i;
                    if (!fetch_valid_i)  state_next = RUN;
                    else if (fsm_ready)  state_next = ISSUE;
                end
                ISSUE: begin
                    if (si_fire) state_next = WAIT;
                end
                WAIT: begin
                    if (ser_done_i) state_next = RUN;
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cnt <= 32'd0;
        end else if ((state == DRAIN || state == WAIT) && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycles_o = stall_cnt;

endmodule

// File: tb/tb_decode_ctrl.sv
// tb/tb_decode_ctrl.sv - table-driven scoreboard bench for decode_ctrl
module tb_decode_ctrl;
    import decode_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [31:0] fetch_pc_i;
    logic [31:0] fetch_instr_i;
    logic        si_valid_o;
    logic        si_ready_i;
    si_t         si_o;
    logic        backend_empty_i;
    logic        ser_done_i;
    logic [31:0] stall_cycles_o;

    always #5 clk = ~clk;

    decode_ctrl #(.SERIALIZE_ALL(1'b0)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .fetch_valid_i   (fetch_valid_i),
        .fetch_ready_o   (fetch_ready_o),
        .fetch_pc_i      (fetch_pc_i),
        .fetch_instr_i   (fetch_instr_i),
        .si_valid_o      (si_valid_o),
        .si_ready_i      (si_ready_i),
        .si_o            (si_o),
        .backend_empty_i (backend_empty_i),
        .ser_done_i      (ser_done_i),
        .stall_cycles_o  (stall_cycles_o)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        ok;
        fu_e         fu;
        op_e         op;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        ser;
    } vec_t;

    typedef struct {
        si_t si;
        int  stamp;
    } exp_t;

    vec_t  vecs[12];
    exp_t  exp_q[$];
    exp_t  mon_e;
    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    stall_exp = 0;
    int    cur = 0;
    bit    accepted = 1'b0;
    bit    lat_chk = 1'b0;
    int    stream_idx[7] = '{0, 1, 2, 3, 4, 5, 11};
    int    bp_idx[4] = '{0, 1, 2, 3};
    int    ser_idx[5] = '{6, 7, 8, 9, 10};
    int    ser_low[5] = '{4, 0, 1, 0, 0};
    int    ser_wait[5] = '{3, 2, 0, 1, 0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic si_t exp_si(input vec_t v);
        si_t s;
        s       = '0;
        s.valid = v.ok;
        s.fu    = v.fu;
        s.op    = v.op;
        s.pc    = v.pc;
        s.imm   = v.imm;
        s.rd    = v.rd;
        return s;
    endfunction

    always @(negedge clk) begin
        if (rst_ni && !flush_i && si_valid_o && si_ready_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL si_unexpected: got pc %0h expected no output", si_o.pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("si_fields", {si_o.valid, si_o.fu, si_o.op, si_o.rd, si_o.imm},
                      {mon_e.si.valid, mon_e.si.fu, mon_e.si.op, mon_e.si.rd, mon_e.si.imm});
                check("si_pc", si_o.pc, mon_e.si.pc);
                if (lat_chk) check("si_latency", cyc - mon_e.stamp, 1);
            end
        end
    end

    task automatic neg();
        exp_t e;
        @(negedge clk);
        accepted = 1'b0;
        if (!rst_ni || flush_i) begin
            exp_q.delete();
        end else if (fetch_valid_i && fetch_ready_o) begin
            accepted = 1'b1;
            e.si     = exp_si(vecs[cur]);
            e.stamp  = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic pos();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input int idx, input logic valid);
        cur           = idx;
        fetch_pc_i    = vecs[idx].pc;
        fetch_instr_i = vecs[idx].instr;
        fetch_valid_i = valid;
    endtask

    task automatic feed(input int idx, output int used);
        bit got;
        got  = 1'b0;
        used = 0;
        present(idx, 1'b1);
        while (!got && used < 20) begin
            neg();
            got = accepted;
            used++;
            pos();
        end
        check("feed_accept", got, 1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        fetch_valid_i = 1'b0;
        while (exp_q.size() != 0 && n < 20) begin
            neg();
            pos();
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic run_ser(input int idx, input int be_low, input int nwait);
        backend_empty_i = (be_low == 0);
        present(idx, 1'b1);
        neg();
        check("ser_run_block", fetch_ready_o, 1'b0);
        pos();
        for (int c = 0; c <= be_low; c++) begin
            backend_empty_i = (c == be_low);
            neg();
            check("ser_drain_state", dut.state, DRAIN);
            check("ser_stall", stall_cycles_o, stall_exp + c);
            check("ser_drain_ready", fetch_ready_o, c == be_low);
            pos();
        end
        stall_exp += be_low + 1;
        fetch_valid_i   = 1'b0;
        backend_empty_i = 1'b1;
        ser_done_i      = 1'b1;
        neg();
        check("ser_issue_state", dut.state, ISSUE);
        pos();
        present(0, 1'b1);
        for (int c = 0; c <= nwait; c++) begin
            ser_done_i = (c == nwait);
            neg();
            check("ser_wait_state", dut.state, WAIT);
            check("ser_wait_block", fetch_ready_o, 1'b0);
            pos();
        end
        ser_done_i = 1'b0;
        stall_exp += nwait + 1;
        neg();
        check("ser_younger_accept", accepted, 1'b1);
        check("ser_back_to_run", dut.state, RUN);
        check("ser_stall_total", stall_cycles_o, stall_exp);
        pos();
        drain();
    endtask

    task automatic enter_wait(input int idx);
        backend_empty_i = 1'b1;
        present(idx, 1'b1);
        neg(); pos();
        neg(); pos();
        fetch_valid_i = 1'b0;
        neg(); pos();
        neg();
        check("enter_wait_state", dut.state, WAIT);
        pos();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1);
    end

    initial begin
        int used;
        int k;
        vecs[0]  = '{32'h0050_0093, 32'h1000, 1'b1, FU_ALU,  OP_ADD,   32'h5,         5'd1, 1'b0};
        vecs[1]  = '{32'h0020_81B3, 32'h1004, 1'b1, FU_ALU,  OP_ADD,   32'h0,         5'd3, 1'b0};
        vecs[2]  = '{32'h0081_2203, 32'h1008, 1'b1, FU_LSU,  OP_LW,    32'h8,         5'd4, 1'b0};
        vecs[3]  = '{32'hFFF2_8293, 32'h100C, 1'b1, FU_ALU,  OP_ADD,   32'hFFFF_FFFF, 5'd5, 1'b0};
        vecs[4]  = '{32'h1234_5337, 32'h1010, 1'b1, FU_ALU,  OP_LUI,   32'h1234_5000, 5'd6, 1'b0};
        vecs[5]  = '{32'h0020_A623, 32'h1014, 1'b1, FU_LSU,  OP_SW,    32'hC,         5'd0, 1'b0};
        vecs[6]  = '{32'h3402_9073, 32'h2000, 1'b1, FU_CSR,  OP_CSRRW, 32'h340,       5'd0, 1'b1};
        vecs[7]  = '{32'h0000_0000, 32'h2004, 1'b0, FU_NONE, OP_NOP,   32'h0,         5'd0, 1'b1};
        vecs[8]  = '{32'h0000_0073, 32'h2008, 1'b1, FU_SYS,  OP_ECALL, 32'h0,         5'd0, 1'b1};
        vecs[9]  = '{32'h3020_0073, 32'h200C, 1'b1, FU_SYS,  OP_MRET,  32'h0,         5'd0, 1'b1};
        vecs[10] = '{32'h0FF0_000F, 32'h2010, 1'b1, FU_SYS,  OP_FENCE, 32'h0,         5'd0, 1'b1};
        vecs[11] = '{32'h4020_83B3, 32'h1018, 1'b1, FU_ALU,  OP_SUB,   32'h0,         5'd7, 1'b0};

        rst_ni          = 1'b0;
        flush_i         = 1'b0;
        si_ready_i      = 1'b1;
        backend_empty_i = 1'b1;
        ser_done_i      = 1'b0;
        present(0, 1'b0);
        pos(); pos();
        rst_ni = 1'b1;
        neg();
        check("rst_si_valid", si_valid_o, 1'b0);
        check("rst_si_zero", si_o, '0);
        check("rst_stall", stall_cycles_o, 0);
        check("rst_state", dut.state, RUN);
        check("rst_occupancy", dut.occupancy, 0);
        check("rst_fetch_ready", fetch_ready_o, 1'b1);
        pos();

        for (int i = 0; i < 12; i++) begin
            present(i, 1'b0);
            neg();
            check("ser_flag", fetch_ready_o, !vecs[i].ser);
            pos();
        end

        lat_chk = 1'b1;
        for (int i = 0; i < 7; i++) begin
            feed(stream_idx[i], used);
            check("stream_rate", used, 1);
        end
        drain();
        check("stream_stall", stall_cycles_o, stall_exp);

        lat_chk    = 1'b0;
        si_ready_i = 1'b0;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            present(bp_idx[k], 1'b1);
            neg();
            if (c == 2) check("bp_ready_low", fetch_ready_o, 1'b0);
            if (c == 4) check("bp_occupancy", dut.occupancy, 2);
            if (accepted) k++;
            pos();
        end
        check("bp_absorbed", k, 2);
        si_ready_i = 1'b1;
        while (k < 4) begin
            feed(bp_idx[k], used);
            k++;
        end
        drain();

        lat_chk = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_ser(ser_idx[i], ser_low[i], ser_wait[i]);
        end

        lat_chk    = 1'b0;
        si_ready_i = 1'b0;
        feed(0, used);
        feed(1, used);
        present(2, 1'b1);
        flush_i = 1'b1;
        neg();
        check("flush_si_valid", si_valid_o, 1'b0);
        check("flush_fetch_ready", fetch_ready_o, 1'b0);
        pos();
        flush_i       = 1'b0;
        fetch_valid_i = 1'b0;
        neg();
        check("flush_occupancy", dut.occupancy, 0);
        check("flush_si_valid_after", si_valid_o, 1'b0);
        pos();
        si_ready_i = 1'b1;
        lat_chk    = 1'b1;
        feed(3, used);
        drain();

        enter_wait(6);
        stall_exp += 2;
        flush_i = 1'b1;
        neg(); pos();
        flush_i = 1'b0;
        stall_exp += 1;
        neg();
        check("flush_wait_state", dut.state, RUN);
        check("flush_keeps_stall", stall_cycles_o, stall_exp);
        pos();
        enter_wait(9);
        flush_i    = 1'b1;
        ser_done_i = 1'b1;
        neg(); pos();
        flush_i    = 1'b0;
        ser_done_i = 1'b0;
        present(0, 1'b1);
        neg();
        check("flush_done_state", dut.state, RUN);
        check("flush_done_accept", accepted, 1'b1);
        pos();
        drain();

        backend_empty_i = 1'b0;
        present(6, 1'b1);
        neg(); pos();
        neg();
        check("rst_mid_drain_state", dut.state, DRAIN);
        pos();
        rst_ni = 1'b0;
        present(0, 1'b0);
        neg(); pos();
        rst_ni = 1'b1;
        backend_empty_i = 1'b1;
        neg();
        check("rst2_state", dut.state, RUN);
        check("rst2_occupancy", dut.occupancy, 0);
        check("rst2_si_valid", si_valid_o, 1'b0);
        check("rst2_si_zero", si_o, '0);
        check("rst2_stall", stall_cycles_o, 0);
        check("rst2_fetch_ready", fetch_ready_o, 1'b1);
        pos();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
